// File: rtl/cic_readout_sched.sv
// cic_readout_sched
//   Sequencer and readout scheduler for a bank of NUM_CH CIC3 decimators.
//   It owns the decimation timebase, holds the filters in reset while idle,
//   throws away the settling frames after enable, snapshots every channel
//   once per decimated period, and drains the snapshot one word per
//   handshake over a valid/ready stream.
//
// Ports
//   clk          modulator clock (shared with the CIC integrators)
//   reset_n      asynchronous reset, active low
//   enable       run request; low returns the block to IDLE on the next clk
//   overrun_clr  one-cycle pulse clearing the sticky overrun flag
//   ch_data      flattened CIC outputs, channel k at [k*WIDTH +: WIDTH]
//   cic_run      filter gate (drives the CIC reset_n at the top level)
//   dout         current word (registered, held while not accepted)
//   dout_ch      channel index of dout
//   dout_valid   dout/dout_ch valid
//   dout_ready   consumer ready; a word moves on valid & ready
//   frame_start  one-cycle pulse on every snapshot taken
//   overrun      sticky: a snapshot fell due while the previous frame was
//                still draining (that snapshot is dropped)
//
// Build option
//   CIC_SCHED_TAG_EN : dout widens to WIDTH+8 and its top byte carries a frame
//                      sequence number. The number advances on every due
//                      snapshot, dropped ones included, so gaps are visible.

module cic_readout_sched #(
   parameter int NUM_CH        = 4,
   parameter int WIDTH         = 25,
   parameter int DECIMATION    = 256,
   parameter int CAPTURE_PHASE = 192,
   parameter int SETTLE_FRAMES = 3,
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
`ifdef CIC_SCHED_TAG_EN
   localparam int DW  = WIDTH + 8
`else
   localparam int DW  = WIDTH
`endif
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    overrun_clr,
   input  logic [NUM_CH*WIDTH-1:0] ch_data,
   output logic                    cic_run,
   output logic [DW-1:0]           dout,
   output logic [CHW-1:0]          dout_ch,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    frame_start,
   output logic                    overrun
);

   localparam int TBW = $clog2(DECIMATION);
   localparam int SCW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_SEND   = 2'd3;

   localparam logic [CHW-1:0] LAST_CH     = CHW'(NUM_CH - 1);
   localparam logic [TBW-1:0] CAP_CNT     = TBW'(CAPTURE_PHASE);
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_FRAMES - 1);

   typedef logic [NUM_CH-1:0][WIDTH-1:0] shadow_t;

   shadow_t ch_vec;
   assign ch_vec = ch_data;

   logic [1:0]       state_q, state_d;
   logic [TBW-1:0]   tb_q, tb_d;
   logic [SCW-1:0]   settle_q, settle_d;
   logic [CHW-1:0]   ch_idx_q, ch_idx_d;
   shadow_t          shadow_q, shadow_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             fs_q, fs_d;
   logic             ovr_q, ovr_d;
   logic             run_q, run_d;
`ifdef CIC_SCHED_TAG_EN
   logic [7:0]       seq_q, seq_d;
   logic [7:0]       tag_q, tag_d;
`endif

   logic           strobe;
   logic           accept;
   logic           last_acc;
   logic           capture;
   logic           drop;
   logic [CHW-1:0] nxt_idx;

   assign strobe   = (tb_q == CAP_CNT) && (state_q != ST_IDLE);
   assign accept   = valid_q && dout_ready;
   assign last_acc = accept && (ch_idx_q == LAST_CH);
   assign nxt_idx  = ch_idx_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      tb_d     = (state_q == ST_IDLE) ? '0 : tb_q + 1'b1;
      settle_d = settle_q;
      ch_idx_d = ch_idx_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = valid_q;
      fs_d     = 1'b0;
      ovr_d    = ovr_q;
      // Every state other than IDLE keeps the filters running while enabled.
      run_d    = enable;
      capture  = 1'b0;
      drop     = 1'b0;
`ifdef CIC_SCHED_TAG_EN
      seq_d    = seq_q;
      tag_d    = tag_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            // The SETTLE_FRAMES-th strobe only moves us on; it is not captured.
            if (strobe) begin
               if (settle_q == SETTLE_LAST) state_d  = ST_WAIT;
               else                         settle_d = settle_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (strobe) capture = 1'b1;
         end
         default: begin // ST_SEND
            if (accept) begin
               if (ch_idx_q == LAST_CH) begin
                  state_d = ST_WAIT;
                  valid_d = 1'b0;
               end else begin
                  ch_idx_d = nxt_idx;
                  data_d   = shadow_q[nxt_idx];
               end
            end
            // A strobe landing exactly on the last-word handshake chains straight
            // into the next frame; any other strobe here loses its snapshot.
            if (strobe) begin
               if (last_acc) capture = 1'b1;
               else          drop    = 1'b1;
            end
         end
      endcase

      if (capture) begin
         state_d  = ST_SEND;
         shadow_d = ch_vec;
         data_d   = ch_vec[0];
         ch_idx_d = '0;
         valid_d  = 1'b1;
         fs_d     = 1'b1;
`ifdef CIC_SCHED_TAG_EN
         tag_d    = seq_q;
         seq_d    = seq_q + 8'd1;
`endif
      end

      // Clear first so a simultaneous overrun event wins.
      if (overrun_clr) ovr_d = 1'b0;
      if (drop) begin
         ovr_d = 1'b1;
`ifdef CIC_SCHED_TAG_EN
         seq_d = seq_q + 8'd1;
`endif
      end

      if (!enable) begin
         state_d  = ST_IDLE;
         tb_d     = '0;
         settle_d = '0;
         ch_idx_d = '0;
         shadow_d = '0;
         data_d   = '0;
         valid_d  = 1'b0;
         fs_d     = 1'b0;
         ovr_d    = 1'b0;
`ifdef CIC_SCHED_TAG_EN
         seq_d    = 8'd0;
         tag_d    = 8'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         tb_q     <= '0;
         settle_q <= '0;
         ch_idx_q <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         fs_q     <= 1'b0;
         ovr_q    <= 1'b0;
         run_q    <= 1'b0;
`ifdef CIC_SCHED_TAG_EN
         seq_q    <= 8'd0;
         tag_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         tb_q     <= tb_d;
         settle_q <= settle_d;
         ch_idx_q <= ch_idx_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         fs_q     <= fs_d;
         ovr_q    <= ovr_d;
         run_q    <= run_d;
`ifdef CIC_SCHED_TAG_EN
         seq_q    <= seq_d;
         tag_q    <= tag_d;
`endif
      end
   end

   assign cic_run     = run_q;
   assign dout_ch     = ch_idx_q;
   assign dout_valid  = valid_q;
   assign frame_start = fs_q;
   assign overrun     = ovr_q;
`ifdef CIC_SCHED_TAG_EN
   assign dout        = {tag_q, data_q};
`else
   assign dout        = data_q;
`endif

endmodule

// File: tb/tb_cic_readout_sched.sv
// tb_cic_readout_sched
//   Randomized bench for cic_readout_sched. A queue-based reference model
//   (elapsed run time, strobe count, queue of pending words) predicts every
//   output each cycle; outputs are sampled on the falling edge.

module tb_cic_readout_sched;
   localparam int NUM_CH = 4;
   localparam int WIDTH  = 25;
   localparam int DEC    = 256;
   localparam int CAP    = 192;
   localparam int SETTLE = 3;
   localparam int CHW    = 2;
`ifdef CIC_SCHED_TAG_EN
   localparam int DW     = WIDTH + 8;
`else
   localparam int DW     = WIDTH;
`endif
   localparam int FIRST_FS = SETTLE*DEC + CAP + 1;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic                    enable = 1'b0;
   logic                    overrun_clr = 1'b0;
   logic                    dout_ready = 1'b0;
   logic [NUM_CH*WIDTH-1:0] ch_data = '0;
   logic                    cic_run, dout_valid, frame_start, overrun;
   logic [DW-1:0]           dout;
   logic [CHW-1:0]          dout_ch;

   always #5 clk = ~clk;

   cic_readout_sched #(
      .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DECIMATION(DEC),
      .CAPTURE_PHASE(CAP), .SETTLE_FRAMES(SETTLE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .overrun_clr(overrun_clr),
      .ch_data(ch_data), .cic_run(cic_run), .dout(dout), .dout_ch(dout_ch),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .frame_start(frame_start), .overrun(overrun)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] w;
      int            ch;
   } word_t;

   word_t      mq[$];
   bit         m_run, m_fs, m_ovr;
   int         m_t, m_nstb;
   logic [7:0] m_seq;

   task automatic m_reset();
      mq.delete();
      m_run = 0; m_fs = 0; m_ovr = 0;
      m_t = 0; m_nstb = 0; m_seq = 8'd0;
   endtask

   task automatic m_update(input bit en, input bit rdy, input bit clr);
      word_t wd;
      if (!reset_n || !en) begin
         m_reset();
         return;
      end
      if (!m_run) begin
         m_run = 1; m_t = 0; m_fs = 0;
         return;
      end
      m_fs = 0;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (clr) m_ovr = 0;
      if ((m_t % DEC) == CAP) begin
         if (m_nstb < SETTLE) m_nstb++;
         else if (mq.size() == 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
`ifdef CIC_SCHED_TAG_EN
               wd.w = {m_seq, ch_data[k*WIDTH +: WIDTH]};
`else
               wd.w = ch_data[k*WIDTH +: WIDTH];
`endif
               wd.ch = k;
               mq.push_back(wd);
            end
            m_fs = 1;
            m_seq = m_seq + 8'd1;
         end else begin
            m_ovr = 1;
            m_seq = m_seq + 8'd1;
         end
      end
      m_t++;
   endtask

   task automatic check_outputs();
      chk("cic_run", 64'(cic_run), 64'(m_run));
      chk("dout_valid", 64'(dout_valid), 64'(mq.size() > 0));
      chk("frame_start", 64'(frame_start), 64'(m_fs));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      if (mq.size() > 0) begin
         chk("dout", 64'(dout), 64'(mq[0].w));
         chk("dout_ch", 64'(dout_ch), 64'(mq[0].ch));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_cic_run"}, 64'(cic_run), 64'd0);
      chk({tag, "_dout"}, 64'(dout), 64'd0);
      chk({tag, "_dout_ch"}, 64'(dout_ch), 64'd0);
      chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
      chk({tag, "_frame_start"}, 64'(frame_start), 64'd0);
      chk({tag, "_overrun"}, 64'(overrun), 64'd0);
   endtask

   // One clock: check current outputs, drive new inputs, advance model.
   task automatic step(input bit en, input bit rdy, input bit clr, input bit ramp);
      check_outputs();
      enable = en; dout_ready = rdy; overrun_clr = clr;
      for (int k = 0; k < NUM_CH; k++)
         ch_data[k*WIDTH +: WIDTH] = ramp ? WIDTH'(k + 1) : WIDTH'($urandom);
      m_update(en, rdy, clr);
      @(negedge clk);
   endtask

   // Enable from IDLE with ready held high; first frame_start latency is fixed.
   task automatic settle_run(input bit ramp, input string tag);
      int fs_at = -1;
      for (int i = 0; i < 1300; i++) begin
         if (frame_start && fs_at < 0) fs_at = i - 1;
         step(1, 1, 0, ramp);
      end
      chk(tag, 64'(fs_at), 64'(FIRST_FS));
   endtask

   initial begin
      bit hit;
      m_reset();
      @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;

      // Plain run, ramp data 1..NUM_CH, ready always high.
      settle_run(1, "first_frame_latency");

      // Stall: ready low long enough for a strobe to overrun, then drain.
      for (int i = 0; i < 600; i++) step(1, 0, 0, 0);
      chk("overrun_after_stall", 64'(overrun), 64'd1);
      for (int i = 0; i < 300; i++) step(1, 1, 0, 0);
      step(1, 1, 1, 0);

      // Hold the last word until the strobe cycle so both coincide.
      for (int i = 0; i < 1500; i++)
         step(1, (mq.size() > 1) || (mq.size() == 1 && (m_t % DEC) == CAP), 0, 0);
      chk("chain_no_overrun", 64'(overrun), 64'd0);

      // Random ready, occasional clear.
      for (int i = 0; i < 2000; i++)
         step(1, $urandom % 2, ($urandom % 100) == 0, 0);

      // Drop enable while ch_idx == 2.
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         if (mq.size() == NUM_CH - 2) hit = 1;
         else step(1, ($urandom % 4) == 0, 0, 0);
      end
      chk("wait_ch_idx2", 64'(hit), 64'd1);
      step(0, $urandom % 2, 0, 0);
      chk("drop_valid", 64'(dout_valid), 64'd0);
      chk("drop_cic_run", 64'(cic_run), 64'd0);
      settle_run(0, "resettle_latency");

      // Asynchronous reset mid-frame.
      hit = 0;
      for (int i = 0; i < 1000 && !hit; i++) begin
         if (mq.size() > 0) hit = 1;
         else step(1, 0, 0, 0);
      end
      chk("wait_frame", 64'(hit), 64'd1);
      #2 reset_n = 1'b0;
      #1 check_zero("async_reset");
      m_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      reset_n = 1'b1;
      settle_run(0, "post_reset_latency");

      // Slow consumer: frequent overruns, random clears.
      for (int i = 0; i < 3000; i++)
         step(1, ($urandom % 32) == 0, ($urandom % 200) == 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
